uart_rx: RTL and testbench

- 8N1 UART receiver; the receive-side counterpart of the team's uart_tx.
- Accepts an asynchronous serial line and synchronises it into the clk domain.
- Detects start bits, samples each bit at mid-period, checks the stop bit.
- Delivers each received byte as a one-cycle valid pulse to the downstream consumer (loopback checker, command parser, FIFO).

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 120 ++++++++++++
 tb/tb_uart_rx.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial-receive bundle: the line into the receiver plus its byte/pulse outputs.
// The slave modport is the receiver; the master modport is the line driver and byte consumer.
interface uart_rx_if;
  logic       i_uart_rx;
  logic [7:0] o_uart_data;
  logic       o_uart_valid;
  logic       o_uart_frame_err;
  logic       o_uart_busy;

  modport slave (
    input  i_uart_rx,
    output o_uart_data,
    output o_uart_valid,
    output o_uart_frame_err,
    output o_uart_busy
  );

  modport master (
    output i_uart_rx,
    input  o_uart_data,
    input  o_uart_valid,
    input  o_uart_frame_err,
    input  o_uart_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the line, samples mid-bit, and emits one-cycle
// valid / frame-error pulses with the last good byte held on o_uart_data.
module uart_rx #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 9600
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  rx_bus
);

  localparam logic [15:0] MCNT_DIV  = 16'(CLOCK_FREQ / BAUD_RATE - 1);
  localparam logic [15:0] MCNT_HALF = 16'((CLOCK_FREQ / BAUD_RATE - 1) / 2);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic        r_sync1, r_sync2, r_hist;
  state_e      r_state, w_state_d;
  logic [15:0] r_div_cnt, w_div_cnt_d;
  logic [2:0]  r_bit_idx, w_bit_idx_d;
  logic [7:0]  r_shift, w_shift_d;
  logic [7:0]  r_data, w_data_d;
  logic        r_valid, w_valid_d;
  logic        r_ferr, w_ferr_d;
  logic        w_fall;

  // All three flops reset high so a line held low through reset is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 1'b1;
    end else begin
      r_sync1 <= rx_bus.i_uart_rx;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_fall = r_hist & ~r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_div_cnt <= 16'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_div_cnt <= w_div_cnt_d;
      r_bit_idx <= w_bit_idx_d;
      r_shift   <= w_shift_d;
      r_data    <= w_data_d;
      r_valid   <= w_valid_d;
      r_ferr    <= w_ferr_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_div_cnt_d = r_div_cnt;
    w_bit_idx_d = r_bit_idx;
    w_shift_d   = r_shift;
    w_data_d    = r_data;
    w_valid_d   = 1'b0;
    w_ferr_d    = 1'b0;
    if (r_state != StIdle) begin
      w_div_cnt_d = r_div_cnt + 16'd1;
    end
    case (r_state)
      StIdle: begin
        if (w_fall) begin
          w_state_d   = StStart;
          w_div_cnt_d = 16'd0;
        end
      end
      StStart: begin
        if (r_div_cnt == MCNT_HALF) begin
          w_div_cnt_d = 16'd0;
          w_bit_idx_d = 3'd0;
          // A line back high at mid-start is a glitch, not a frame.
          w_state_d   = r_sync2 ? StIdle : StData;
        end
      end
      StData: begin
        if (r_div_cnt == MCNT_DIV) begin
          w_div_cnt_d = 16'd0;
          w_shift_d   = {r_sync2, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_d = StStop;
          end else begin
            w_bit_idx_d = r_bit_idx + 3'd1;
          end
        end
      end
      StStop: begin
        if (r_div_cnt == MCNT_DIV) begin
          w_div_cnt_d = 16'd0;
          w_state_d   = StIdle;
          if (r_sync2) begin
            w_data_d  = r_shift;
            w_valid_d = 1'b1;
          end else begin
            w_ferr_d  = 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign rx_bus.o_uart_data      = r_data;
  assign rx_bus.o_uart_valid     = r_valid;
  assign rx_bus.o_uart_frame_err = r_ferr;
  assign rx_bus.o_uart_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 1 MHz / 100 kbaud (10-clk bits, 10 time units per clk).
module tb_uart_rx;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  exp_t q[$];
  logic prev_pulse;

  uart_rx_if u_if ();

  uart_rx #(
    .CLOCK_FREQ(1_000_000),
    .BAUD_RATE (100_000)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_bus(u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Places the start edge 1 unit before a rising clk edge.
  task automatic align();
    @(posedge clk);
    #9;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int bit_t);
    u_if.i_uart_rx = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      u_if.i_uart_rx = b[i];
      #(bit_t);
    end
    u_if.i_uart_rx = stop_bit;
    #(bit_t);
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) begin
      prev_pulse = 1'b0;
    end else begin
      if (u_if.o_uart_valid || u_if.o_uart_frame_err) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pulse actual valid=%0b ferr=%0b data=%0h required no pulse",
                   u_if.o_uart_valid, u_if.o_uart_frame_err, u_if.o_uart_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_kind", {30'd0, u_if.o_uart_frame_err, u_if.o_uart_valid},
              {30'd0, e.ferr, ~e.ferr});
          chk("pulse_data", {24'd0, u_if.o_uart_data}, {24'd0, e.data});
          chk("busy_at_pulse", {31'd0, u_if.o_uart_busy}, 32'd0);
        end
        if (prev_pulse) begin
          n_checks++;
          n_errors++;
          $display("FAIL pulse_width actual=2+ cycles required=1 cycle");
        end
      end
      prev_pulse = u_if.o_uart_valid | u_if.o_uart_frame_err;
    end
  end

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    prev_pulse     = 1'b0;
    u_if.i_uart_rx = 1'b1;
    rst            = 1'b1;
    #12;
    chk("rst_data",  {24'd0, u_if.o_uart_data}, 32'h00);
    chk("rst_valid", {31'd0, u_if.o_uart_valid}, 32'd0);
    chk("rst_ferr",  {31'd0, u_if.o_uart_frame_err}, 32'd0);
    chk("rst_busy",  {31'd0, u_if.o_uart_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #100;

    // Single ideal frame; busy must be up 4.5 clk after the edge.
    chk("idle_busy", {31'd0, u_if.o_uart_busy}, 32'd0);
    q.push_back('{ferr: 1'b0, data: 8'hA5});
    align();
    fork
      send_byte(8'hA5, 1'b1, 100);
      begin
        #45;
        chk("a5_busy_early", {31'd0, u_if.o_uart_busy}, 32'd1);
      end
    join
    #200;

    // Back-to-back frames, as from a loopback transmitter.
    q.push_back('{ferr: 1'b0, data: 8'h00});
    q.push_back('{ferr: 1'b0, data: 8'hFF});
    q.push_back('{ferr: 1'b0, data: 8'h55});
    q.push_back('{ferr: 1'b0, data: 8'h3C});
    align();
    send_byte(8'h00, 1'b1, 100);
    send_byte(8'hFF, 1'b1, 100);
    send_byte(8'h55, 1'b1, 100);
    send_byte(8'h3C, 1'b1, 100);
    #200;

    // Stop bit low, then line held low: one frame error, data keeps 8'h3C.
    q.push_back('{ferr: 1'b1, data: 8'h3C});
    align();
    send_byte(8'h81, 1'b0, 100);
    #150;
    chk("held_low_busy", {31'd0, u_if.o_uart_busy}, 32'd0);
    #150;
    u_if.i_uart_rx = 1'b1;
    #200;
    chk("after_break_busy", {31'd0, u_if.o_uart_busy}, 32'd0);
    chk("after_break_data", {24'd0, u_if.o_uart_data}, 32'h3C);

    // 3-clk glitch: a short busy window and nothing else.
    align();
    u_if.i_uart_rx = 1'b0;
    #30;
    u_if.i_uart_rx = 1'b1;
    #10;
    chk("glitch_busy_up", {31'd0, u_if.o_uart_busy}, 32'd1);
    #100;
    chk("glitch_busy_down", {31'd0, u_if.o_uart_busy}, 32'd0);
    chk("glitch_data", {24'd0, u_if.o_uart_data}, 32'h3C);

    // Baud skew of +4% and -4%.
    q.push_back('{ferr: 1'b0, data: 8'hC3});
    align();
    send_byte(8'hC3, 1'b1, 104);
    #200;
    q.push_back('{ferr: 1'b0, data: 8'hC3});
    align();
    send_byte(8'hC3, 1'b1, 96);
    #200;
    chk("skew_data", {24'd0, u_if.o_uart_data}, 32'hC3);

    // Reset during data bit 4; held until the aborted frame is off the line.
    align();
    fork
      send_byte(8'h5A, 1'b1, 100);
      begin
        #553;
        rst = 1'b1;
        #1;
        chk("midrst_data",  {24'd0, u_if.o_uart_data}, 32'h00);
        chk("midrst_valid", {31'd0, u_if.o_uart_valid}, 32'd0);
        chk("midrst_ferr",  {31'd0, u_if.o_uart_frame_err}, 32'd0);
        chk("midrst_busy",  {31'd0, u_if.o_uart_busy}, 32'd0);
      end
    join
    #50;
    @(negedge clk);
    rst = 1'b0;
    #100;
    q.push_back('{ferr: 1'b0, data: 8'h12});
    align();
    send_byte(8'h12, 1'b1, 100);
    #200;
    chk("final_data", {24'd0, u_if.o_uart_data}, 32'h12);
    chk("all_expected_seen", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
